// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation controller.
// Sequences an external modular multiplier with at most one outstanding request.
module modexp_ctrl #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 ready_in,
    input  logic [WIDTH-1:0]     base_in,
    input  logic [EXP_WIDTH-1:0] exponent_in,
    input  logic [WIDTH-1:0]     modulus_in,
    output logic [WIDTH-1:0]     result_out,
    output logic                 busy_out,
    output logic                 valid_out,
    output logic                 mul_ready_out,
    output logic [WIDTH-1:0]     mul_a_out,
    output logic [WIDTH-1:0]     mul_b_out,
    output logic [WIDTH-1:0]     mul_modulus_out,
    input  logic                 mul_busy_in,
    input  logic                 mul_valid_in,
    input  logic [WIDTH-1:0]     mul_result_in
);

    localparam int CW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [CW-1:0] BITS_INIT = CW'(EXP_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        MUL_REQ,
        MUL_WAIT,
        SQ_REQ,
        SQ_WAIT,
        NEXT,
        DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_base;
    logic [WIDTH-1:0]     r_mod;
    logic [WIDTH-1:0]     r_acc;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [CW-1:0]        r_bitcnt;
    logic                 r_first;
    logic                 r_busy;
    logic                 r_busy_d;
    logic [WIDTH-1:0]     r_result;
    logic                 r_mul_ready;
    logic [WIDTH-1:0]     r_mul_a;
    logic [WIDTH-1:0]     r_mul_b;
    logic                 w_cur_bit;
    logic                 w_exp_zero;

    // The bit under consideration always sits at the MSB of the shift register.
    assign w_cur_bit  = r_exp[EXP_WIDTH-1];
    assign w_exp_zero = (r_exp == '0);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:     if (ready_in) w_state_nxt = SCAN;
            SCAN: begin
                if (w_exp_zero)     w_state_nxt = DONE;
                else if (w_cur_bit) w_state_nxt = MUL_REQ;
            end
            MUL_REQ:  w_state_nxt = MUL_WAIT;
            SQ_REQ:   w_state_nxt = SQ_WAIT;
            MUL_WAIT: if (mul_valid_in) w_state_nxt = NEXT;
            SQ_WAIT:  if (mul_valid_in) w_state_nxt = w_cur_bit ? MUL_REQ : NEXT;
            NEXT:     w_state_nxt = (r_bitcnt == '0) ? DONE : SQ_REQ;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_base      <= '0;
            r_mod       <= '0;
            r_acc       <= '0;
            r_exp       <= '0;
            r_bitcnt    <= '0;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_busy_d    <= 1'b0;
            r_result    <= '0;
            r_mul_ready <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            r_busy_d    <= r_busy;
            r_mul_ready <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (ready_in) begin
                        r_base   <= base_in;
                        r_mod    <= modulus_in;
                        r_exp    <= exponent_in;
                        r_bitcnt <= BITS_INIT;
                        r_first  <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (w_exp_zero) begin
                        r_acc <= (r_mod == WIDTH'(1)) ? '0 : WIDTH'(1);
                    end else if (!w_cur_bit) begin
                        r_exp    <= r_exp << 1;
                        r_bitcnt <= r_bitcnt - CW'(1);
                    end
                end
                // First multiply is 1*base so the base gets reduced even if >= modulus.
                MUL_REQ: begin
                    r_mul_a     <= r_first ? WIDTH'(1) : r_acc;
                    r_mul_b     <= r_base;
                    r_mul_ready <= 1'b1;
                    r_first     <= 1'b0;
                end
                SQ_REQ: begin
                    r_mul_a     <= r_acc;
                    r_mul_b     <= r_acc;
                    r_mul_ready <= 1'b1;
                end
                MUL_WAIT, SQ_WAIT: begin
                    if (mul_valid_in) r_acc <= mul_result_in;
                end
                NEXT: begin
                    if (r_bitcnt != '0) begin
                        r_exp    <= r_exp << 1;
                        r_bitcnt <= r_bitcnt - CW'(1);
                    end
                end
                DONE: begin
                    r_result <= r_acc;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign result_out      = r_result;
    assign busy_out        = r_busy;
    assign valid_out       = r_busy_d & ~r_busy;
    assign mul_ready_out   = r_mul_ready;
    assign mul_a_out       = r_mul_a;
    assign mul_b_out       = r_mul_b;
    assign mul_modulus_out = r_mod;

    // A new request must never land on a multiplier that still reports busy.
    a_no_req_while_busy: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        !(mul_ready_out && mul_busy_in));

endmodule
